// File: rtl/coinc_acq_sequencer.sv
// coinc_acq_sequencer: sequences the coincidence counter bank through timed
// acquisition windows (arm, count, snapshot) and streams each 512-bit snapshot
// out as WORD_W-bit words over a valid/ready handshake.
// Optional feature macro: COINC_FRAME_HEADER_EN (prefixes each frame with a
// {8'hC0, 8'h00, seq[15:0]} header word).
module coinc_acq_sequencer #(
    parameter int unsigned GATE_W = 32,
    parameter int unsigned NWORDS = 16,
    parameter int unsigned WORD_W = 32
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     continuous,
    input  logic [GATE_W-1:0]        gate_len,
    input  logic [NWORDS*WORD_W-1:0] stats,
    output logic                     cnt_enable,
    output logic                     cnt_clear,
    output logic [WORD_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     overrun
);

`ifdef COINC_FRAME_HEADER_EN
    localparam int unsigned HDR_WORDS = 1;
`else
    localparam int unsigned HDR_WORDS = 0;
`endif
    localparam int unsigned FRAME_WORDS = NWORDS + HDR_WORDS;
    localparam int unsigned FRAME_W     = FRAME_WORDS * WORD_W;
    localparam int unsigned IDX_W       = $clog2(FRAME_WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_COUNT = 2'd2,
        S_SNAP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [GATE_W-1:0]   timer_q, timer_d;
    logic                cnt_enable_q, cnt_enable_d;
    logic                cnt_clear_q, cnt_clear_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                capture;
    logic                handshake;
    logic                ser_free;
`ifdef COINC_FRAME_HEADER_EN
    logic [15:0]         seq_q, seq_d;
`endif

    // Acquisition FSM next state, window timer and overrun flag
    always_comb begin
        state_d   = state_q;
        gate_d    = gate_q;
        timer_d   = timer_q;
        overrun_d = overrun_q;
        capture   = 1'b0;
        handshake = valid_q && out_ready;
        // A last-word handshake in the SNAP cycle frees the shadow in time
        ser_free  = !valid_q || (handshake && last_q);

        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d   = S_ARM;
                        gate_d    = gate_len;
                        overrun_d = 1'b0;
                    end
                end
                S_ARM: begin
                    timer_d = gate_q - GATE_W'(2);
                    state_d = (gate_q <= GATE_W'(1)) ? S_SNAP : S_COUNT;
                end
                S_COUNT: begin
                    if (timer_q == '0) begin
                        state_d = S_SNAP;
                    end else begin
                        timer_d = timer_q - GATE_W'(1);
                    end
                end
                S_SNAP: begin
                    if (ser_free) begin
                        capture = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                    state_d = continuous ? S_ARM : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        cnt_enable_d = (state_d == S_ARM) || (state_d == S_COUNT);
        cnt_clear_d  = (state_d == S_ARM);
        busy_d       = (state_d != S_IDLE);
    end

    // Snapshot shadow / serializer: shifts one word down per handshake
    always_comb begin
        frame_d = frame_q;
        valid_d = valid_q;
        last_d  = last_q;
        idx_d   = idx_q;
`ifdef COINC_FRAME_HEADER_EN
        seq_d   = seq_q;
`endif
        if (capture) begin
`ifdef COINC_FRAME_HEADER_EN
            frame_d = {stats, WORD_W'({8'hC0, 8'h00, seq_q})};
            seq_d   = seq_q + 16'd1;
`else
            frame_d = stats;
`endif
            valid_d = 1'b1;
            idx_d   = '0;
            last_d  = 1'b0;
        end else if (handshake) begin
            if (last_q) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                idx_d   = '0;
            end else begin
                frame_d = frame_q >> WORD_W;
                idx_d   = idx_q + IDX_W'(1);
                last_d  = (idx_q == IDX_W'(FRAME_WORDS - 2));
            end
        end
    end

    // State and output registers with synchronous clear
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q      <= S_IDLE;
            gate_q       <= '0;
            timer_q      <= '0;
            cnt_enable_q <= 1'b0;
            cnt_clear_q  <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            frame_q      <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            idx_q        <= '0;
`ifdef COINC_FRAME_HEADER_EN
            seq_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            gate_q       <= gate_d;
            timer_q      <= timer_d;
            cnt_enable_q <= cnt_enable_d;
            cnt_clear_q  <= cnt_clear_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            frame_q      <= frame_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            idx_q        <= idx_d;
`ifdef COINC_FRAME_HEADER_EN
            seq_q        <= seq_d;
`endif
        end
    end

    assign cnt_enable = cnt_enable_q;
    assign cnt_clear  = cnt_clear_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign out_data   = frame_q[WORD_W-1:0];
    assign out_valid  = valid_q;
    assign out_last   = last_q;

endmodule

// File: tb/tb_coinc_acq_sequencer.sv
// Testbench for coinc_acq_sequencer: a small counter-bank model feeds stats,
// directed vectors run single-shot windows, hand sequences cover stop,
// overrun and continuous operation. Honours COINC_FRAME_HEADER_EN.
module tb_coinc_acq_sequencer;

`ifdef COINC_FRAME_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int NTOT = 16 + HDR;

    logic         clk;
    logic         clear;
    logic         start;
    logic         stop;
    logic         continuous;
    logic [31:0]  gate_len;
    logic [511:0] stats;
    logic         cnt_enable;
    logic         cnt_clear;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
    logic         overrun;

    logic [47:0]  clk_cnt;
    logic [15:0]  tag;

    int total = 0;
    int bad   = 0;
    int tb_seq = 0;

    coinc_acq_sequencer dut (
        .clk        (clk),
        .clear      (clear),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .gate_len   (gate_len),
        .stats      (stats),
        .cnt_enable (cnt_enable),
        .cnt_clear  (cnt_clear),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter bank model: clock field counts enabled cycles, clear loads 1
    always_ff @(posedge clk) begin
        if (cnt_clear) clk_cnt <= 48'd1;
        else if (cnt_enable) clk_cnt <= clk_cnt + 48'd1;
    end

    // Remaining stats fields: a per-test tag plus the word index
    always_comb begin
        stats        = '0;
        stats[47:0]  = clk_cnt;
        stats[63:48] = tag;
        for (int k = 2; k < 16; k++) stats[k*32 +: 32] = {tag, 16'(k)};
    end

    typedef struct {
        logic [31:0] gate;
        bit          toggle;
        logic [15:0] vtag;
        int          exp_clk;
        int          exp_en;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [31:0] exp_word(int j, int clkv, logic [15:0] t, int seq);
        int k;
        k = j - HDR;
        if (k < 0) return {8'hC0, 8'h00, 16'(seq)};
        if (k == 0) return 32'(clkv);
        if (k == 1) return {t, 16'h0000};
        return {t, 16'(k)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drains one frame, checking order, out_last and stability during stalls
    task automatic collect(input bit toggle, input int exp_clk, input logic [15:0] t,
                           input int seq, output int en_cnt);
        int          recv;
        int          cyc;
        bit          done;
        bit          phase;
        logic        prev_stall;
        logic [31:0] prev_data;
        recv = 0; cyc = 0; done = 0; phase = 1'b1;
        prev_stall = 1'b0; prev_data = '0; en_cnt = 0;
        while (!done && cyc < 400) begin
            if (cnt_enable) en_cnt++;
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_data), 64'(prev_data));
            end
            out_ready = toggle ? phase : 1'b1;
            phase = !phase;
            if (out_valid && out_ready) begin
                chk($sformatf("word%0d", recv), 64'(out_data), 64'(exp_word(recv, exp_clk, t, seq)));
                chk($sformatf("last%0d", recv), 64'(out_last), 64'(recv == NTOT - 1));
                recv++;
                if (out_last) done = 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            @(negedge clk);
            cyc++;
        end
        chk("frame_len", 64'(recv), 64'(NTOT));
    endtask

    initial begin
        int          en;
        int          cyc;
        logic        seen;
        logic [15:0] old_tag;

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          en;
        int          cyc;
        logic        seen;
        logic [15:0] old_tag;

        vecs[0] = '{32'd10, 1'b0, 16'h1111, 10, 10};
        vecs[1] = '{32'd0,  1'b0, 16'h2222, 1,  1};
        vecs[2] = '{32'd1,  1'b0, 16'h3333, 1,  1};
        vecs[3] = '{32'd2,  1'b1, 16'h4444, 2,  2};
        vecs[4] = '{32'd17, 1'b1, 16'h5555, 17, 17};
        vecs[5] = '{32'd3,  1'b0, 16'h6666, 3,  3};

        clear = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        gate_len = '0; out_ready = 1'b0; tag = '0;
        repeat (3) @(negedge clk);
        chk("rst_cnt_enable", 64'(cnt_enable), 64'd0);
        chk("rst_cnt_clear", 64'(cnt_clear), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        clear = 1'b0;
        @(negedge clk);

        // Single-shot windows from the vector table
        for (int i = 0; i < 6; i++) begin
            tag = vecs[i].vtag;
            gate_len = vecs[i].gate;
            continuous = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            collect(vecs[i].toggle, vecs[i].exp_clk, vecs[i].vtag, tb_seq, en);
            tb_seq++;
            chk($sformatf("v%0d_en_cycles", i), 64'(en), 64'(vecs[i].exp_en));
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
            chk($sformatf("v%0d_valid_after", i), 64'(out_valid), 64'd0);
        end

        // Stop on the third COUNT cycle aborts without a snapshot
        tag = 16'hABCD; gate_len = 32'd20; out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("arm_cnt_clear", 64'(cnt_clear), 64'd1);
        chk("arm_cnt_enable", 64'(cnt_enable), 64'd1);
        @(negedge clk);
        chk("count_cnt_clear", 64'(cnt_clear), 64'd0);
        @(negedge clk);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_cnt_enable", 64'(cnt_enable), 64'd0);
        chk("stop_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("stop_no_valid", 64'(seen), 64'd0);

        // Continuous with stalled readout: second snapshot drops, overrun sets
        old_tag = 16'h7777; tag = old_tag;
        gate_len = 32'd8; continuous = 1'b1; out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("ovr_first_valid", 64'(out_valid), 64'd1);
        tag = 16'h7778;
        cyc = 0;
        while (!overrun && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("ovr_set", 64'(overrun), 64'd1);
        chk("ovr_held_valid", 64'(out_valid), 64'd1);
        chk("ovr_held_w0", 64'(out_data), 64'(exp_word(0, 8, old_tag, tb_seq)));
        chk("ovr_busy", 64'(busy), 64'd1);
        stop = 1'b1; continuous = 1'b0;
        @(negedge clk);
        stop = 1'b0;
        chk("ovr_stop_busy", 64'(busy), 64'd0);
        chk("ovr_sticky", 64'(overrun), 64'd1);
        collect(1'b0, 8, old_tag, tb_seq, en);
        tb_seq++;
        tag = 16'h9999; gate_len = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ovr_cleared", 64'(overrun), 64'd0);
        collect(1'b0, 5, 16'h9999, tb_seq, en);
        tb_seq++;
        chk("ovr_next_en", 64'(en), 64'd5);

        // Start and stop together in IDLE: start wins
        tag = 16'h4242; gate_len = 32'd4;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", 64'(busy), 64'd1);
        collect(1'b0, 4, 16'h4242, tb_seq, en);
        tb_seq++;
        chk("startstop_en", 64'(en), 64'd4);

        // Fresh clear, then three continuous frames with ready held high
        clear = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b0;
        tb_seq = 0;
        tag = 16'h8888; gate_len = 32'd20; continuous = 1'b1; out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect(1'b0, 20, 16'h8888, 0, en);
        collect(1'b0, 20, 16'h8888, 1, en);
        continuous = 1'b0;
        collect(1'b0, 20, 16'h8888, 2, en);
        repeat (3) @(negedge clk);
        chk("cont_busy_end", 64'(busy), 64'd0);
        chk("cont_no_overrun", 64'(overrun), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coinc_acq_sequencer.md
Name: coinc_acq_sequencer

Overview:
- Sequences the 4-channel coincidence counter bank through timed acquisition windows: clear/arm, count for a programmed gate, snapshot the 512-bit stats vector.
- Streams each snapshot to the readout path as 16 x 32-bit words over a valid/ready handshake.
- Single-shot and continuous modes. Snapshot shadow register lets the next window count while the previous one drains.

Parameters:
- GATE_W, 32, width of gate length and window timer
- NWORDS, 16, readout words per snapshot; fixed at 512/WORD_W
- WORD_W, 32, readout word width

Ports:
- clk  in  1  system clock; counter bank runs on the same clock
- clear  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins acquisition; honoured only in IDLE
- stop  in  1  one-cycle pulse; aborts the current window, no snapshot
- continuous  in  1  1 = re-arm automatically after each SNAP; sampled at SNAP
- gate_len  in  GATE_W  window length in clk cycles; latched on accepted start
- stats  in  512  counter bank output
- cnt_enable  out  1  to counter bank enable
- cnt_clear  out  1  to counter bank clear
- out_data  out  WORD_W  readout word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_last  out  1  marks the final word of a frame
- busy  out  1  acquisition FSM not in IDLE
- overrun  out  1  sticky; a snapshot was dropped; cleared by accepted start

Behaviour:
- Reset (clear=1): FSM=IDLE, all outputs 0, serializer empty, gate latch 0, word index 0.
- Acquisition FSM states: IDLE, ARM, COUNT, SNAP.
- IDLE: cnt_enable=0, cnt_clear=0. On start -> ARM, latch gate_len, clear overrun.
- ARM (1 cycle): cnt_clear=1, cnt_enable=1. Counter loads clock word=1.
  - Timer loaded with gate_len-2.
  - If gate_len<=1, go directly to SNAP; else -> COUNT.
- COUNT: cnt_enable=1, cnt_clear=0. Timer decrements; at 0 -> SNAP.
  - Total enabled cycles = max(gate_len,1).
  - stats[47:0] seen in SNAP equals max(gate_len,1).
- SNAP (1 cycle): cnt_enable=0. Capture stats into shadow only if the serializer is empty; otherwise drop and set overrun.
  - Then -> ARM if continuous=1, else IDLE.
- stop in ARM/COUNT/SNAP: -> IDLE next cycle, cnt_enable=0, no capture. Serializer unaffected. stop in IDLE: ignored.
- start while busy: ignored. start and stop in the same cycle in IDLE: start wins.
- Serializer runs independently of the FSM.
  - After capture: out_valid=1 the next cycle, word k = shadow[32k+31:32k], k=0..15, ascending.
  - Advances only on out_valid && out_ready.
  - out_data, out_valid and out_last stay stable while out_valid && !out_ready.
  - out_last=1 on word 15. After its handshake the serializer is empty, out_valid=0.
  - A capture and a last-word handshake in the same cycle count as empty: capture succeeds, new frame word 0 valid the next cycle.
- Back-to-back: with out_ready held 1 and gate_len>=17, no snapshot is ever dropped.
- 48-bit clock field straddles words 0 and 1; the host reassembles it. The block performs no field reformatting.

Optional Feature:
- Macro: COINC_FRAME_HEADER_EN
- Defined:
  - Each frame is prefixed with one header word {8'hC0, 8'h00, seq[15:0]}, making 17 words per frame; out_last stays on the final data word.
  - seq is a 16-bit frame counter: increments per captured frame, wraps 16'hFFFF->0, resets to 0 on clear, not incremented on dropped snapshots.
- Undefined: 16 data words only; no seq register.

Test Plan:
- Reset then start, gate_len=10, continuous=0, out_ready=1, channel inputs constant 4'b0011 -> cnt_enable high exactly 10 cycles; words: w0=10, w1=0, w2=10, w3=10, w4=0, w5=0, w6=10, rest 0; out_last on w15; FSM returns to IDLE.
- gate_len=0 and gate_len=1 -> single enabled cycle (ARM only); w0=1.
- continuous=1, gate_len=8, out_ready=0 throughout -> first frame held on w0 stable; second SNAP drops it and raises overrun; next start clears overrun.
- stop asserted on the 3rd COUNT cycle -> cnt_enable low the next cycle; no out_valid; busy=0.
- out_ready toggled 1010... during a frame -> 16 words in order, none duplicated or skipped, data stable during stalls.
- With COINC_FRAME_HEADER_EN, three continuous frames with out_ready=1 and gate_len=20 -> headers 0xC0000000, 0xC0000001, 0xC0000002; 17 words per frame.
